// File: rtl/seq_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_if
// Purpose  : Groups the configuration, serial-input and result signals of
//            seq_detector into one bundle.
// Ports    : (interface signals)
//            cfg_valid, cfg_pattern[PAT_W], cfg_len[clog2(PAT_W+1)],
//            cfg_overlap, clear, in_valid, in  -> driven by the master
//            out, match_count[CNT_W]           -> driven by the detector
// Modports : master (bit source / controller), slave (detector)
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) ();
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             cfg_valid;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             clear;
    logic             in_valid;
    logic             in;
    logic             out;
    logic [CNT_W-1:0] match_count;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap,
        output clear, in_valid, in,
        input  out, match_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap,
        input  clear, in_valid, in,
        output out, match_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector
// Purpose  : Runtime-programmable serial bit-sequence detector with bubble
//            handling (in_valid), optional overlap and a saturating match
//            counter. Out of reset it behaves as an overlapping "101" detector.
// Ports    : clock  - rising-edge clock
//            reset  - asynchronous, active-high reset
//            bus    - seq_detector_if.slave (config, serial input, out,
//                     match_count)
//            debug_hist, debug_armed - only when SEQ_DET_DEBUG_EN is defined
// Options  : SEQ_DET_DEBUG_EN - exposes the history register and ARMED flag
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  wire logic        clock,
    input  wire logic        reset,
    seq_detector_if.slave    bus
`ifdef SEQ_DET_DEBUG_EN
    ,
    output logic [PAT_W-1:0] debug_hist,
    output logic             debug_armed
`endif
);
    localparam int                 c_LEN_W   = $clog2(PAT_W + 1);
    localparam logic [c_LEN_W-1:0] c_PAT_LEN = c_LEN_W'(PAT_W);
    localparam logic [c_LEN_W-1:0] c_RST_LEN = c_LEN_W'(3);
    localparam logic [PAT_W-1:0]   c_RST_PAT = PAT_W'(3'b101);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t             r_state,  w_state_n;
    logic [PAT_W-1:0]   r_hist,   w_hist_n;
    logic [c_LEN_W-1:0] r_fill,   w_fill_n;
    logic [PAT_W-1:0]   r_pat,    w_pat_n;
    logic [c_LEN_W-1:0] r_len,    w_len_n;
    logic               r_ovl,    w_ovl_n;
    logic               r_out,    w_out_n;
    logic [CNT_W-1:0]   r_count,  w_count_n;

    logic [PAT_W-1:0]   w_mask;
    logic [PAT_W-1:0]   w_hist_shift;
    logic [c_LEN_W-1:0] w_fill_inc;
    logic [c_LEN_W-1:0] w_cfg_len;
    logic               w_accept;
    logic               w_match;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= c_RST_PAT;
            r_len   <= c_RST_LEN;
            r_ovl   <= 1'b1;
            r_out   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_n;
            r_hist  <= w_hist_n;
            r_fill  <= w_fill_n;
            r_pat   <= w_pat_n;
            r_len   <= w_len_n;
            r_ovl   <= w_ovl_n;
            r_out   <= w_out_n;
            r_count <= w_count_n;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_hist_n  = r_hist;
        w_fill_n  = r_fill;
        w_pat_n   = r_pat;
        w_len_n   = r_len;
        w_ovl_n   = r_ovl;
        w_out_n   = 1'b0;
        w_count_n = r_count;
        w_state_n = r_state;

        // Low len bits select the active part of the pattern/history.
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end

        w_hist_shift = {r_hist[PAT_W-2:0], bus.in};
        w_fill_inc   = (r_fill >= c_PAT_LEN) ? c_PAT_LEN : (r_fill + 1'b1);

        // A zero or oversized length means "use the full pattern width".
        w_cfg_len = ((bus.cfg_len == '0) || (bus.cfg_len > c_PAT_LEN)) ?
                    c_PAT_LEN : bus.cfg_len;

        w_accept = bus.in_valid && !bus.clear && !bus.cfg_valid;

        // In ARMED the fill test is already satisfied; in FILL the incoming
        // bit may be the one that completes the required length.
        w_match = w_accept &&
                  ((r_state == ST_ARMED) || (w_fill_inc >= r_len)) &&
                  ((w_hist_shift & w_mask) == (r_pat & w_mask));

        if (bus.clear) begin
            w_hist_n  = '0;
            w_fill_n  = '0;
            w_count_n = '0;
        end else if (bus.cfg_valid) begin
            w_pat_n  = bus.cfg_pattern;
            w_len_n  = w_cfg_len;
            w_ovl_n  = bus.cfg_overlap;
            w_hist_n = '0;
            w_fill_n = '0;
        end else if (bus.in_valid) begin
            w_hist_n = w_hist_shift;
            w_fill_n = w_fill_inc;
            if (w_match) begin
                w_out_n = 1'b1;
                if (r_count != '1) begin
                    w_count_n = r_count + 1'b1;
                end
                // Non-overlapping mode: the next match needs a fresh len bits.
                if (!r_ovl) begin
                    w_fill_n = '0;
                end
            end
        end

        w_state_n = (w_fill_n >= w_len_n) ? ST_ARMED : ST_FILL;
    end

    assign bus.out         = r_out;
    assign bus.match_count = r_count;

`ifdef SEQ_DET_DEBUG_EN
    assign debug_hist  = r_hist;
    assign debug_armed = (r_state == ST_ARMED);
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector
// Purpose  : Self-checking bench for seq_detector. Two instances (CNT_W=8 and
//            CNT_W=2) share one stimulus stream. A queue-based model of the
//            matching rules predicts out/match_count every cycle, and directed
//            literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector;
    localparam int PW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    seq_detector_if #(.PAT_W(PW), .CNT_W(8)) bus8 ();
    seq_detector_if #(.PAT_W(PW), .CNT_W(2)) bus2 ();

    assign bus2.cfg_valid   = bus8.cfg_valid;
    assign bus2.cfg_pattern = bus8.cfg_pattern;
    assign bus2.cfg_len     = bus8.cfg_len;
    assign bus2.cfg_overlap = bus8.cfg_overlap;
    assign bus2.clear       = bus8.clear;
    assign bus2.in_valid    = bus8.in_valid;
    assign bus2.in          = bus8.in;

    seq_detector #(.PAT_W(PW), .CNT_W(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8)
    );

    seq_detector #(.PAT_W(PW), .CNT_W(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_tot  = 0;
    logic [15:0] obs = '0;   // out of dut8 after each driven cycle, newest in [0]

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Model: remembers accepted bits since the last restart and matches the
    // newest len of them against the pattern.
    // ------------------------------------------------------------------------
    bit          mq[$];
    logic [3:0]  m_pat = 4'b0101;
    int          m_len = 3;
    bit          m_ovl = 1'b1;
    bit          m_out = 1'b0;
    int          m_c8  = 0;
    int          m_c2  = 0;

    always @(posedge clock or posedge reset) begin
        bit hit;
        if (reset) begin
            mq.delete();
            m_pat = 4'b0101; m_len = 3; m_ovl = 1'b1;
            m_out = 1'b0; m_c8 = 0; m_c2 = 0;
        end else if (bus8.clear) begin
            mq.delete();
            m_out = 1'b0; m_c8 = 0; m_c2 = 0;
        end else if (bus8.cfg_valid) begin
            m_pat = bus8.cfg_pattern;
            m_len = (bus8.cfg_len == 0 || int'(bus8.cfg_len) > PW) ? PW : int'(bus8.cfg_len);
            m_ovl = bus8.cfg_overlap;
            mq.delete();
            m_out = 1'b0;
        end else if (bus8.in_valid) begin
            mq.push_back(bus8.in);
            if (mq.size() > 16) void'(mq.pop_front());
            hit = (mq.size() >= m_len);
            if (hit) begin
                for (int k = 0; k < m_len; k++)
                    if (mq[mq.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            end
            m_out = hit;
            if (hit) begin
                m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
                m_c2 = (m_c2 < 3)   ? m_c2 + 1 : 3;
                if (!m_ovl) mq.delete();
            end
        end else begin
            m_out = 1'b0;
        end
    end

    always @(negedge clock) begin
        chk("model_out8",   32'(bus8.out),         32'(m_out));
        chk("model_count8", 32'(bus8.match_count), 32'(m_c8));
        chk("model_out2",   32'(bus2.out),         32'(m_out));
        chk("model_count2", 32'(bus2.match_count), 32'(m_c2));
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // ------------------------------------------------------------------------
    task automatic drive(input logic cv, input logic cl, input logic iv, input logic b);
        @(negedge clock);
        bus8.cfg_valid = cv;
        bus8.clear     = cl;
        bus8.in_valid  = iv;
        bus8.in        = b;
        @(posedge clock);
        #1;
        obs = {obs[14:0], bus8.out};
    endtask

    task automatic send(input logic b);
        drive(1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [3:0] p, input logic [2:0] l, input logic o);
        bus8.cfg_pattern = p;
        bus8.cfg_len     = l;
        bus8.cfg_overlap = o;
        drive(1'b1, 1'b0, 1'b1, 1'b1);   // same-cycle bit must be dropped
    endtask

    initial begin
        logic [4:0] s5;
        logic [6:0] s7;
        bus8.cfg_valid = 1'b0; bus8.clear = 1'b0; bus8.in_valid = 1'b0; bus8.in = 1'b0;
        bus8.cfg_pattern = '0; bus8.cfg_len = '0; bus8.cfg_overlap = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_out",   32'(bus8.out),         32'd0);
        chk("reset_count", 32'(bus8.match_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Legacy 101 overlapping detector
        s5 = 5'b10101;
        for (int i = 4; i >= 0; i--) send(s5[i]);
        chk("t1_pulses", 32'(obs[4:0]),          32'b00101);
        chk("t1_count",  32'(bus8.match_count),  32'd2);
        idle();

        // Non-overlapping 101
        clr();
        cfg(4'b0101, 3'd3, 1'b0);
        for (int i = 4; i >= 0; i--) send(s5[i]);
        chk("t2_pulses", 32'(obs[4:0]),          32'b00100);
        chk("t2_count",  32'(bus8.match_count),  32'd1);
        idle();

        // 1101, overlap, contiguous then with bubbles
        clr();
        cfg(4'b1101, 3'd4, 1'b1);
        s7 = 7'b1101101;
        for (int i = 6; i >= 0; i--) send(s7[i]);
        chk("t3_pulses", 32'(obs[6:0]),          32'b0001001);
        chk("t3_count",  32'(bus8.match_count),  32'd2);
        clr();
        for (int i = 6; i >= 0; i--) begin
            send(s7[i]);
            if (i != 0) idle();
        end
        chk("t3_bubble_pulses", 32'(obs[12:0]),  32'b0000001000001);
        chk("t3_bubble_count",  32'(bus8.match_count), 32'd2);
        idle();

        // len 1, back-to-back matches and counter saturation
        clr();
        cfg(4'b0001, 3'd1, 1'b1);
        repeat (8) send(1'b1);
        chk("t4_pulses",  32'(obs[7:0]),          32'hFF);
        chk("t4_count2",  32'(bus2.match_count),  32'd3);
        chk("t4_count8",  32'(bus8.match_count),  32'd8);
        idle();
        chk("t4_bubble_out", 32'(obs[0]),          32'd0);

        // clear wins over cfg_valid and in_valid
        cfg(4'b0101, 3'd3, 1'b1);
        send(1'b1); send(1'b0); send(1'b1);
        chk("t5_count_kept", 32'(bus8.match_count), 32'd9);
        bus8.cfg_pattern = 4'b1111; bus8.cfg_len = 3'd4; bus8.cfg_overlap = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_clr_out",   32'(obs[0]),           32'd0);
        chk("t5_clr_count", 32'(bus8.match_count), 32'd0);
        send(1'b1); send(1'b0); send(1'b1);
        chk("t5_old_pat",   32'(obs[2:0]),         32'b001);
        send(1'b0); send(1'b1);
        chk("t5_old_ovl",   32'(obs[1:0]),         32'b01);
        chk("t5_count",     32'(bus8.match_count), 32'd2);

        // asynchronous reset mid-stream
        send(1'b1); send(1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_count", 32'(bus8.match_count), 32'd0);
        chk("t6_async_out",   32'(bus8.out),         32'd0);
        @(negedge clock);
        reset = 1'b0;
        bus8.in_valid = 1'b0;
        send(1'b1);
        chk("t6_no_partial",  32'(obs[0]),           32'd0);
        send(1'b0); send(1'b1);
        chk("t6_pulse",       32'(obs[1:0]),         32'b01);
        chk("t6_count",       32'(bus8.match_count), 32'd1);
        idle();

        // cfg_len 0 is taken as the full width
        cfg(4'b1010, 3'd0, 1'b1);
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        chk("t7_len_clamp",   32'(obs[3:0]),         32'b0001);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
`default_nettype wire
